// File: rtl/ui_pkg.sv
// ui_pkg: shared definitions for the UI scene/click controller.
//   scene_t : 3-bit scene encoding driven out on ui_scene_ctrl.scene
//   CD_W    : width of purchase cooldown and result hold counters (frames)
//   COORD_W : mouse coordinate width
//   HIT_W   : widened compare width so x0+wd never wraps
package ui_pkg;

  localparam int CD_W    = 8;
  localparam int COORD_W = 10;
  localparam int HIT_W   = 11;

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_MENU  = 3'd1,
    S_PLAY  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4,
    S_PAUSE = 3'd5
  } scene_t;

endpackage

// File: rtl/ui_rect_hit.sv
// ui_rect_hit: combinational "cursor inside rectangle" test.
//   Parameters X0/Y0 (top-left corner), WD/HT (size) in pixels.
//   x, y : cursor position
//   hit  : x in [X0, X0+WD) and y in [Y0, Y0+HT)
// Compares run one bit wider than the coordinates so the far edge of a
// box touching the top of the coordinate range cannot wrap to zero.
module ui_rect_hit
  import ui_pkg::*;
#(
  parameter int X0 = 0,
  parameter int Y0 = 0,
  parameter int WD = 1,
  parameter int HT = 1
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               hit
);

  localparam logic [HIT_W-1:0] XL = HIT_W'(X0);
  localparam logic [HIT_W-1:0] XH = HIT_W'(X0 + WD);
  localparam logic [HIT_W-1:0] YL = HIT_W'(Y0);
  localparam logic [HIT_W-1:0] YH = HIT_W'(Y0 + HT);

  logic [HIT_W-1:0] xe;
  logic [HIT_W-1:0] ye;

  assign xe  = {1'b0, x};
  assign ye  = {1'b0, y};
  assign hit = (xe >= XL) && (xe < XH) && (ye >= YL) && (ye < YH);

endmodule

// File: rtl/ui_scene_ctrl.sv
// ui_scene_ctrl: scene FSM and click decode for the tower-defence game.
// Sits between the mouse controller and the game engine / renderer.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   frame_tick    : one-cycle pulse per video frame (cooldown / hold time base)
//   mouse_x/y     : cursor position
//   mouse_l/r     : button levels (mouse_r only used with PAUSE_EN)
//   btn_hit       : cursor inside purchase button i
//   btn_afford    : engine reports button i affordable
//   game_win/lose : engine result flags (win has priority)
//   scene         : current scene (ui_pkg::scene_t), also the FSM state
//   level         : selected level index
//   game_init     : one-cycle pulse on the first PLAY cycle after MENU
//   buy_pulse     : one-hot one-cycle purchase strobe
//   btn_ready     : button i purchasable now (render highlight)
//   hover_level   : cursor on level button i, only while in MENU
//
// Optional feature macro: PAUSE_EN
//   defined   : right-click toggles PLAY <-> PAUSE; PAUSE freezes cooldowns
//               and ignores left clicks and the win/lose flags.
//   undefined : mouse_r unused, S_PAUSE unreachable.
//
// Handshake: there are no valid/ready pairs; every input is a level sampled
// each clk, clicks are rising edges of mouse_l/mouse_r, and every strobe
// output (game_init, buy_pulse) is registered and high for exactly one cycle.
module ui_scene_ctrl
  import ui_pkg::*;
#(
  parameter int NUM_LEVELS  = 3,
  parameter int NUM_BTN     = 10,
  parameter int START_X0    = 200,
  parameter int START_Y0    = 270,
  parameter int START_WD    = 240,
  parameter int START_HT    = 60,
  parameter int LVL_X0      = 160,
  parameter int LVL_Y0      = 80,
  parameter int LVL_WD      = 320,
  parameter int LVL_HT      = 60,
  parameter int LVL_PITCH   = 120,
  parameter int BTN_CD      = 15,
  parameter int RESULT_HOLD = 90,
  localparam int LVL_IW     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic [COORD_W-1:0]    mouse_x,
  input  logic [COORD_W-1:0]    mouse_y,
  input  logic                  mouse_l,
  input  logic                  mouse_r,
  input  logic [NUM_BTN-1:0]    btn_hit,
  input  logic [NUM_BTN-1:0]    btn_afford,
  input  logic                  game_win,
  input  logic                  game_lose,
  output logic [2:0]            scene,
  output logic [LVL_IW-1:0]     level,
  output logic                  game_init,
  output logic [NUM_BTN-1:0]    buy_pulse,
  output logic [NUM_BTN-1:0]    btn_ready,
  output logic [NUM_LEVELS-1:0] hover_level
);

  scene_t                scene_q;
  logic                  mouse_l_q;
  logic                  click_l;
  logic                  click_r;
  logic                  start_hit;
  logic [NUM_LEVELS-1:0] lvl_hit;
  logic                  lvl_any;
  logic [LVL_IW-1:0]     lvl_pick;
  logic [CD_W-1:0]       cd [NUM_BTN];
  logic [NUM_BTN-1:0]    cd_zero;
  logic [NUM_BTN-1:0]    buy_cand;
  logic [NUM_BTN-1:0]    buy_sel;
  logic [CD_W-1:0]       hold;

  assign scene = scene_q;

  // ---------------------------------------------------------------------
  // Click edge detection. Edge registers reset high so a button held down
  // through reset is not seen as a fresh press on release of rst.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) mouse_l_q <= 1'b1;
    else     mouse_l_q <= mouse_l;
  end

  assign click_l = mouse_l & ~mouse_l_q;

`ifdef PAUSE_EN
  logic mouse_r_q;

  always_ff @(posedge clk) begin
    if (rst) mouse_r_q <= 1'b1;
    else     mouse_r_q <= mouse_r;
  end

  assign click_r = mouse_r & ~mouse_r_q;
`else
  logic unused_mouse_r;

  assign unused_mouse_r = mouse_r;
  assign click_r        = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Hit tests
  // ---------------------------------------------------------------------
  ui_rect_hit #(
    .X0 (START_X0),
    .Y0 (START_Y0),
    .WD (START_WD),
    .HT (START_HT)
  ) u_start_hit (
    .x   (mouse_x),
    .y   (mouse_y),
    .hit (start_hit)
  );

  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_lvl
    ui_rect_hit #(
      .X0 (LVL_X0),
      .Y0 (LVL_Y0 + g * LVL_PITCH),
      .WD (LVL_WD),
      .HT (LVL_HT)
    ) u_lvl_hit (
      .x   (mouse_x),
      .y   (mouse_y),
      .hit (lvl_hit[g])
    );
  end

  assign hover_level = (scene_q == S_MENU) ? lvl_hit : '0;

  // Lowest hovered level wins; scanning downwards leaves the lowest index.
  always_comb begin
    lvl_any  = |lvl_hit;
    lvl_pick = '0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (lvl_hit[i]) lvl_pick = LVL_IW'(i);
    end
  end

  // ---------------------------------------------------------------------
  // Purchase arbitration: lowest index that is hit, affordable and cool.
  // cand & (~cand + 1) isolates the lowest set bit.
  // ---------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_cdz
    assign cd_zero[b] = (cd[b] == '0);
  end

  assign buy_cand  = btn_hit & btn_afford & cd_zero;
  assign buy_sel   = buy_cand & (~buy_cand + NUM_BTN'(1));
  assign btn_ready = (scene_q == S_PLAY) ? (btn_afford & cd_zero) : '0;

  // ---------------------------------------------------------------------
  // Scene FSM with registered strobes, cooldowns and result hold timer.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      scene_q   <= S_START;
      level     <= '0;
      game_init <= 1'b0;
      buy_pulse <= '0;
      hold      <= '0;
      for (int i = 0; i < NUM_BTN; i++) cd[i] <= '0;
    end else begin
      game_init <= 1'b0;
      buy_pulse <= '0;

      case (scene_q)
        S_START: begin
          if (click_l && start_hit) scene_q <= S_MENU;
        end

        S_MENU: begin
          if (click_l && lvl_any) begin
            level     <= lvl_pick;
            scene_q   <= S_PLAY;
            game_init <= 1'b1;
          end
        end

        S_PLAY: begin
          if (game_win || game_lose) begin
            // Leaving PLAY drops all cooldowns; a coincident click is lost.
            scene_q <= game_win ? S_WIN : S_LOSE;
            hold    <= CD_W'(RESULT_HOLD);
            for (int i = 0; i < NUM_BTN; i++) cd[i] <= '0;
          end else begin
            if (click_r) scene_q <= S_PAUSE;
            for (int i = 0; i < NUM_BTN; i++) begin
              // A load on a frame_tick cycle takes the full cooldown.
              if (click_l && buy_sel[i])        cd[i] <= CD_W'(BTN_CD);
              else if (frame_tick && !cd_zero[i]) cd[i] <= cd[i] - 1'b1;
            end
            if (click_l) buy_pulse <= buy_sel;
          end
        end

        S_WIN, S_LOSE: begin
          if (hold != '0) begin
            if (frame_tick) hold <= hold - 1'b1;
          end else if (click_l) begin
            scene_q <= S_MENU;
          end
        end

`ifdef PAUSE_EN
        S_PAUSE: begin
          // Cooldowns and hold stay frozen; only right-click resumes.
          if (click_r) scene_q <= S_PLAY;
        end
`endif

        default: scene_q <= S_START;
      endcase
    end
  end

endmodule

// File: tb/tb_ui_scene_ctrl.sv
// tb_ui_scene_ctrl: self-checking bench for ui_scene_ctrl (default params).
module tb_ui_scene_ctrl;
  import ui_pkg::*;

  localparam int NL  = 3;
  localparam int NB  = 10;
  localparam int SX = 200, SY = 270, SW = 240, SH = 60;
  localparam int LX = 160, LY = 80, LW = 320, LH = 60, LP = 120;
  localparam int CDV  = 15;
  localparam int HOLD = 90;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          frame_tick = 1'b0;
  logic [9:0]    mouse_x = '0, mouse_y = '0;
  logic          mouse_l = 1'b0, mouse_r = 1'b0;
  logic [NB-1:0] btn_hit = '0, btn_afford = '0;
  logic          game_win = 1'b0, game_lose = 1'b0;
  logic [2:0]    scene;
  logic [1:0]    level;
  logic          game_init;
  logic [NB-1:0] buy_pulse, btn_ready;
  logic [NL-1:0] hover_level;

  ui_scene_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .mouse_l     (mouse_l),
    .mouse_r     (mouse_r),
    .btn_hit     (btn_hit),
    .btn_afford  (btn_afford),
    .game_win    (game_win),
    .game_lose   (game_lose),
    .scene       (scene),
    .level       (level),
    .game_init   (game_init),
    .buy_pulse   (buy_pulse),
    .btn_ready   (btn_ready),
    .hover_level (hover_level)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cd_m[NB];
  logic [1:0] level_m = '0;

  // ---------------- reference model helpers ----------------
  function automatic logic in_start(int x, int y);
    return (x >= SX) && (x < SX + SW) && (y >= SY) && (y < SY + SH);
  endfunction

  // Level buttons as rows: row index from the pitch, hit if inside the row's box.
  function automatic logic [NL-1:0] m_hover(int x, int y);
    m_hover = '0;
    if (x >= LX && x < LX + LW && y >= LY) begin
      int row = (y - LY) / LP;
      if (row < NL && ((y - LY) % LP) < LH) m_hover[row] = 1'b1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  // Rising edge of mouse_l at (x,y); on return the edge has been sampled.
  task automatic press(int x, int y);
    mouse_x = 10'(x);
    mouse_y = 10'(y);
    mouse_l = 1'b1;
    cyc();
    mouse_l = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int x, y;
    mouse_l = 1'b1; mouse_x = 10'd300; mouse_y = 10'd300; rst = 1'b1;
    repeat (3) cyc();
    n_checks++; if (scene !== S_START) begin $display("FAIL reset_scene got %0d exp %0d", scene, S_START); n_fail++; end
    n_checks++; if (level !== 2'd0) begin $display("FAIL reset_level got %0d exp 0", level); n_fail++; end
    n_checks++; if (game_init !== 1'b0 || buy_pulse !== '0) begin $display("FAIL reset_strobes got init=%b buy=%b exp 0", game_init, buy_pulse); n_fail++; end
    n_checks++; if (hover_level !== '0 || btn_ready !== '0) begin $display("FAIL reset_hover_ready got %b %b exp 0", hover_level, btn_ready); n_fail++; end
    rst = 1'b0;
    repeat (3) cyc();
    n_checks++; if (scene !== S_START) begin $display("FAIL held_click_at_reset got %0d exp %0d", scene, S_START); n_fail++; end
    mouse_l = 1'b0; cyc();
    repeat (4) begin
      do begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end while (in_start(x, y));
      press(x, y);
      n_checks++; if (scene !== S_START) begin $display("FAIL start_miss (%0d,%0d) got %0d exp %0d", x, y, scene, S_START); n_fail++; end
      cyc();
    end
    press(300, 300);
    n_checks++; if (scene !== S_MENU) begin $display("FAIL start_click got %0d exp %0d", scene, S_MENU); n_fail++; end
    cyc();
  endtask

  task automatic test_menu();
    int x, y;
    repeat (40) begin
      x = $urandom_range(0, 639); y = $urandom_range(0, 479);
      mouse_x = 10'(x); mouse_y = 10'(y);
      cyc();
      n_checks++; if (hover_level !== m_hover(x, y)) begin $display("FAIL hover (%0d,%0d) got %b exp %b", x, y, hover_level, m_hover(x, y)); n_fail++; end
      if (m_hover(x, y) == '0) begin
        press(x, y);
        n_checks++; if (scene !== S_MENU) begin $display("FAIL menu_miss got %0d exp %0d", scene, S_MENU); n_fail++; end
        cyc();
      end
    end
    press(200, 210);
    level_m = 2'd1;
    n_checks++; if (scene !== S_PLAY || level !== level_m) begin $display("FAIL menu_select got scene=%0d level=%0d exp %0d %0d", scene, level, S_PLAY, level_m); n_fail++; end
    n_checks++; if (game_init !== 1'b1) begin $display("FAIL game_init_rise got %b exp 1", game_init); n_fail++; end
    mouse_x = 10'd200; mouse_y = 10'd100;
    cyc();
    n_checks++; if (game_init !== 1'b0) begin $display("FAIL game_init_width got %b exp 0", game_init); n_fail++; end
    n_checks++; if (hover_level !== '0) begin $display("FAIL hover_in_play got %b exp 0", hover_level); n_fail++; end
  endtask

  task automatic test_purchase();
    btn_hit = 10'b0000000110; btn_afford = '1;
    cyc();
    n_checks++; if (btn_ready !== {NB{1'b1}}) begin $display("FAIL ready_initial got %b exp all", btn_ready); n_fail++; end
    press(0, 0);
    n_checks++; if (buy_pulse !== 10'b0000000010) begin $display("FAIL buy_first got %b exp 0000000010", buy_pulse); n_fail++; end
    cyc();
    n_checks++; if (buy_pulse !== '0) begin $display("FAIL buy_width got %b exp 0", buy_pulse); n_fail++; end
    n_checks++; if (btn_ready !== 10'b1111111101) begin $display("FAIL ready_after_buy got %b exp 1111111101", btn_ready); n_fail++; end
    // button 1 cooling, so the lowest eligible hit is now button 2
    press(0, 0);
    n_checks++; if (buy_pulse !== 10'b0000000100) begin $display("FAIL buy_next_lowest got %b exp 0000000100", buy_pulse); n_fail++; end
    cyc();
    press(0, 0);
    n_checks++; if (buy_pulse !== '0) begin $display("FAIL buy_both_cooling got %b exp 0", buy_pulse); n_fail++; end
    cyc();
    frames(14);
    press(0, 0);
    n_checks++; if (buy_pulse !== '0) begin $display("FAIL buy_before_cd got %b exp 0", buy_pulse); n_fail++; end
    cyc();
    frames(1);
    press(0, 0);
    n_checks++; if (buy_pulse !== 10'b0000000010) begin $display("FAIL buy_after_cd got %b exp 0000000010", buy_pulse); n_fail++; end
    cyc();
    frames(20);
    for (int i = 0; i < NB; i++) cd_m[i] = 0;
  endtask

  task automatic test_purchase_random();
    logic ml, ml_prev, ft, click;
    logic [NB-1:0] hit, aff, exp_buy, exp_rdy;
    int sel;
    ml_prev = 1'b0;
    repeat (300) begin
      hit = NB'($urandom); aff = NB'($urandom);
      ml = ($urandom_range(0, 2) == 0); ft = ($urandom_range(0, 3) == 0);
      click = ml & ~ml_prev;
      sel = -1;
      if (click) begin
        for (int i = NB - 1; i >= 0; i--) if (hit[i] && aff[i] && cd_m[i] == 0) sel = i;
      end
      exp_buy = '0;
      if (sel >= 0) exp_buy[sel] = 1'b1;
      for (int i = 0; i < NB; i++) begin
        if (i == sel) cd_m[i] = CDV;
        else if (ft && cd_m[i] > 0) cd_m[i]--;
      end
      btn_hit = hit; btn_afford = aff; mouse_l = ml; frame_tick = ft;
      cyc();
      for (int i = 0; i < NB; i++) exp_rdy[i] = aff[i] && (cd_m[i] == 0);
      n_checks++; if (buy_pulse !== exp_buy) begin $display("FAIL rand_buy got %b exp %b", buy_pulse, exp_buy); n_fail++; end
      n_checks++; if (btn_ready !== exp_rdy) begin $display("FAIL rand_ready got %b exp %b", btn_ready, exp_rdy); n_fail++; end
      ml_prev = ml;
    end
    mouse_l = 1'b0; frame_tick = 1'b0;
    cyc();
  endtask

  task automatic test_win_priority();
    btn_hit = 10'b1; btn_afford = '1;
    frames(20);
    game_win = 1'b1; game_lose = 1'b1;
    press(0, 0);
    game_win = 1'b0; game_lose = 1'b0;
    n_checks++; if (scene !== S_WIN) begin $display("FAIL win_priority got %0d exp %0d", scene, S_WIN); n_fail++; end
    n_checks++; if (buy_pulse !== '0) begin $display("FAIL buy_on_win got %b exp 0", buy_pulse); n_fail++; end
    n_checks++; if (btn_ready !== '0) begin $display("FAIL ready_in_win got %b exp 0", btn_ready); n_fail++; end
    cyc();
  endtask

  task automatic test_result_hold();
    int x, y;
    frames(HOLD - 1);
    press($urandom_range(0, 639), $urandom_range(0, 479));
    n_checks++; if (scene !== S_WIN) begin $display("FAIL hold_click_ignored got %0d exp %0d", scene, S_WIN); n_fail++; end
    cyc();
    frames(1);
    press($urandom_range(0, 639), $urandom_range(0, 479));
    n_checks++; if (scene !== S_MENU || level !== level_m) begin $display("FAIL hold_release got scene=%0d level=%0d exp %0d %0d", scene, level, S_MENU, level_m); n_fail++; end
    cyc();
    x = $urandom_range(LX, LX + LW - 1); y = $urandom_range(LY, LY + LH - 1);
    press(x, y);
    level_m = 2'd0;
    n_checks++; if (scene !== S_PLAY || level !== level_m || game_init !== 1'b1) begin $display("FAIL reenter got scene=%0d level=%0d init=%b exp %0d %0d 1", scene, level, game_init, S_PLAY, level_m); n_fail++; end
    n_checks++; if (btn_ready !== {NB{1'b1}}) begin $display("FAIL cd_cleared got %b exp all", btn_ready); n_fail++; end
    cyc();
  endtask

  task automatic test_levels_random();
    int l;
    repeat (3) begin
      game_lose = 1'b1; cyc(); game_lose = 1'b0;
      n_checks++; if (scene !== S_LOSE) begin $display("FAIL lose_entry got %0d exp %0d", scene, S_LOSE); n_fail++; end
      frames(HOLD);
      press($urandom_range(0, 639), $urandom_range(0, 479));
      n_checks++; if (scene !== S_MENU || level !== level_m) begin $display("FAIL lose_to_menu got scene=%0d level=%0d exp %0d %0d", scene, level, S_MENU, level_m); n_fail++; end
      cyc();
      l = $urandom_range(0, NL - 1);
      press($urandom_range(LX, LX + LW - 1), LY + l * LP + $urandom_range(0, LH - 1));
      level_m = 2'(l);
      n_checks++; if (scene !== S_PLAY || level !== level_m) begin $display("FAIL level_pick got scene=%0d level=%0d exp %0d %0d", scene, level, S_PLAY, level_m); n_fail++; end
      cyc();
    end
  endtask

`ifdef PAUSE_EN
  task automatic test_pause();
    btn_hit = 10'b1; btn_afford = '1;
    frames(20);
    press(0, 0); cyc();
    mouse_r = 1'b1; cyc(); mouse_r = 1'b0;
    n_checks++; if (scene !== S_PAUSE || btn_ready !== '0) begin $display("FAIL pause_entry got scene=%0d ready=%b exp %0d 0", scene, btn_ready, S_PAUSE); n_fail++; end
    frames(20);
    game_win = 1'b1; press(0, 0); game_win = 1'b0;
    n_checks++; if (scene !== S_PAUSE || buy_pulse !== '0) begin $display("FAIL pause_ignores got scene=%0d buy=%b exp %0d 0", scene, buy_pulse, S_PAUSE); n_fail++; end
    cyc();
    mouse_r = 1'b1; cyc(); mouse_r = 1'b0;
    n_checks++; if (scene !== S_PLAY || btn_ready !== 10'b1111111110) begin $display("FAIL pause_frozen_cd got scene=%0d ready=%b exp %0d 1111111110", scene, btn_ready, S_PLAY); n_fail++; end
    frames(CDV);
    n_checks++; if (btn_ready !== {NB{1'b1}}) begin $display("FAIL resume_cd got %b exp all", btn_ready); n_fail++; end
  endtask
`endif

  task automatic test_reset_midflight();
    btn_hit = 10'b1; btn_afford = '1;
    frames(20);
    mouse_l = 1'b1; rst = 1'b1;
    cyc();
    n_checks++; if (buy_pulse !== '0 || scene !== S_START || level !== 2'd0) begin $display("FAIL reset_midflight got buy=%b scene=%0d level=%0d exp 0 %0d 0", buy_pulse, scene, level, S_START); n_fail++; end
    rst = 1'b0; mouse_l = 1'b0;
    cyc();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_menu();
    test_purchase();
    test_purchase_random();
    test_win_priority();
    test_result_hold();
    test_levels_random();
`ifdef PAUSE_EN
    test_pause();
`endif
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
